pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage in-order pipeline (IF, ID, EX, MEM, WB).
- Drives the write-enable and flush (bubble-insert) inputs of the PC register and the four inter-stage write-enabled registers.
- Tracks multi-cycle multiply/divide occupancy of EX with an FSM and down-counter.
- Resolves branch, exception, load-use and memory-wait events by fixed priority.

---
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the hazard event inputs and the stall/flush control outputs that
// pass between the pipeline datapath and the hazard controller.
//
// Signals:
//   i_load_use, i_mul_start, i_div_start, i_branch_taken,
//   i_mem_exc, i_imem_stall, i_dmem_stall      hazard events from the pipeline
//   o_*_we                                     pipeline register write enables
//   o_*_flush                                  bubble insert (only with _we)
//   o_pc_sel_exc                               PC loads the exception vector
//   o_ex_busy, o_muldiv_done                   mul/div occupancy status
//
// Modports:
//   master : pipeline side (drives events, receives controls)
//   slave  : hazard controller side
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
   logic i_load_use;
   logic i_mul_start;
   logic i_div_start;
   logic i_branch_taken;
   logic i_mem_exc;
   logic i_imem_stall;
   logic i_dmem_stall;

   logic o_pc_we;
   logic o_if_id_we;
   logic o_id_ex_we;
   logic o_ex_mem_we;
   logic o_mem_wb_we;
   logic o_if_id_flush;
   logic o_id_ex_flush;
   logic o_ex_mem_flush;
   logic o_mem_wb_flush;
   logic o_pc_sel_exc;
   logic o_ex_busy;
   logic o_muldiv_done;

   modport master (
      output i_load_use, i_mul_start, i_div_start, i_branch_taken,
             i_mem_exc, i_imem_stall, i_dmem_stall,
      input  o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_mem_wb_we,
             o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
             o_pc_sel_exc, o_ex_busy, o_muldiv_done
   );

   modport slave (
      input  i_load_use, i_mul_start, i_div_start, i_branch_taken,
             i_mem_exc, i_imem_stall, i_dmem_stall,
      output o_pc_we, o_if_id_we, o_id_ex_we, o_ex_mem_we, o_mem_wb_we,
             o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush,
             o_pc_sel_exc, o_ex_busy, o_muldiv_done
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for a 5-stage in-order pipeline. Tracks
// multi-cycle mul/div occupancy of EX (RUN/BUSY/DONE FSM plus down-counter)
// and resolves exception, dmem wait, EX busy, branch, load-use and imem wait
// in that fixed priority order.
//
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   hz      pipe_hazard_ctrl_if.slave (events in, stall/flush controls out)
//   o_stall_cycles, o_flush_events  (only with PIPE_HAZARD_PERF_EN defined)
//
// Optional feature macro: PIPE_HAZARD_PERF_EN adds two 32-bit wrapping
// performance counters (cycles with PC held, cycles with any flush).
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 34,
   parameter int CNT_W   = 6
) (
   input logic clk,
   input logic resetn,
   pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0] o_stall_cycles,
   output logic [31:0] o_flush_events
`endif
);

   typedef enum logic [1:0] {RUN, BUSY, DONE} state_t;

   // The start cycle itself is one EX cycle, and the DONE cycle another,
   // so the counter only has to cover LAT-2 cycles in between.
   localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 2);
   localparam bit               MUL_MULTI = (MUL_LAT > 2);
   localparam bit               DIV_MULTI = (DIV_LAT > 2);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic start_any;
   logic ex_busy;
   logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
   logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic pc_sel_exc;

   assign start_any = hz.i_mul_start | hz.i_div_start;
   assign ex_busy   = ((state == RUN) && start_any) || (state == BUSY);

   // State and counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic. An exception aborts any mul/div in flight. A start
   // is only recognised in RUN, so a start held into BUSY/DONE (or held
   // across a dmem freeze) never re-arms the counter.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (hz.i_mem_exc) begin
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else begin
         case (state)
            RUN: begin
               if (hz.i_div_start) begin
                  cnt_nxt   = DIV_LOAD;
                  state_nxt = DIV_MULTI ? BUSY : DONE;
               end else if (hz.i_mul_start) begin
                  cnt_nxt   = MUL_LOAD;
                  state_nxt = MUL_MULTI ? BUSY : DONE;
               end
            end
            BUSY: begin
               if (!hz.i_dmem_stall) begin
                  cnt_nxt = cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state_nxt = DONE;
                  end
               end
            end
            DONE: begin
               if (ex_mem_we && !ex_mem_flush) begin
                  state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Fixed-priority stall/flush resolution. While EX is busy the result
   // of the instruction in EX is not yet meaningful, so branch and
   // load-use are ignored; a bubble is pushed into MEM instead.
   always_comb begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      id_ex_we     = 1'b1;
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      pc_sel_exc   = 1'b0;
      if (hz.i_mem_exc) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
         pc_sel_exc   = 1'b1;
      end else if (hz.i_dmem_stall) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
      end else if (ex_busy) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         ex_mem_flush = 1'b1;
      end else if (hz.i_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (hz.i_load_use) begin
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (hz.i_imem_stall) begin
         pc_we       = 1'b0;
         if_id_flush = 1'b1;
      end
   end

   // While reset is held the pipeline registers are left free-running
   // with no bubbles, independent of whatever the event inputs are doing.
   always_comb begin
      if (!resetn) begin
         hz.o_pc_we        = 1'b1;
         hz.o_if_id_we     = 1'b1;
         hz.o_id_ex_we     = 1'b1;
         hz.o_ex_mem_we    = 1'b1;
         hz.o_mem_wb_we    = 1'b1;
         hz.o_if_id_flush  = 1'b0;
         hz.o_id_ex_flush  = 1'b0;
         hz.o_ex_mem_flush = 1'b0;
         hz.o_mem_wb_flush = 1'b0;
         hz.o_pc_sel_exc   = 1'b0;
         hz.o_ex_busy      = 1'b0;
         hz.o_muldiv_done  = 1'b0;
      end else begin
         hz.o_pc_we        = pc_we;
         hz.o_if_id_we     = if_id_we;
         hz.o_id_ex_we     = id_ex_we;
         hz.o_ex_mem_we    = ex_mem_we;
         hz.o_mem_wb_we    = mem_wb_we;
         hz.o_if_id_flush  = if_id_flush;
         hz.o_id_ex_flush  = id_ex_flush;
         hz.o_ex_mem_flush = ex_mem_flush;
         hz.o_mem_wb_flush = mem_wb_flush;
         hz.o_pc_sel_exc   = pc_sel_exc;
         hz.o_ex_busy      = ex_busy;
         hz.o_muldiv_done  = (state == DONE);
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   // Performance counters; plain 32-bit adds wrap naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         o_stall_cycles <= '0;
         o_flush_events <= '0;
      end else begin
         if (!pc_we) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
         end
         if (if_id_flush || id_ex_flush || ex_mem_flush || mem_wb_flush) begin
            o_flush_events <= o_flush_events + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (MUL_LAT=4, DIV_LAT=34). Outputs are
// packed into a 12-bit word and compared against hand-derived patterns:
//   {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
//    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
//    pc_sel_exc, ex_busy, muldiv_done}
// Honours PIPE_HAZARD_PERF_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam logic [11:0] P_IDLE    = 12'b11111_0000_000;
   localparam logic [11:0] P_BUSY    = 12'b00011_0010_010;
   localparam logic [11:0] P_DONE    = 12'b11111_0000_001;
   localparam logic [11:0] P_BSTALL  = 12'b00000_0000_010;
   localparam logic [11:0] P_DSTALL  = 12'b00000_0000_001;
   localparam logic [11:0] P_EXCBUSY = 12'b11111_1111_110;
   localparam logic [11:0] P_EXC     = 12'b11111_1111_100;
   localparam logic [11:0] P_BRANCH  = 12'b11111_1100_000;
   localparam logic [11:0] P_LDUSE   = 12'b00111_0100_000;
   localparam logic [11:0] P_IMEM    = 12'b01111_1000_000;

   logic clk;
   logic resetn;
   int   errors;
   int   checks;

   pipe_hazard_ctrl_if hz ();

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
`endif

   pipe_hazard_ctrl #(
      .MUL_LAT(4),
      .DIV_LAT(34),
      .CNT_W  (6)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .hz    (hz.slave)
`ifdef PIPE_HAZARD_PERF_EN
      ,
      .o_stall_cycles(stall_cycles),
      .o_flush_events(flush_events)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic lu, input logic mul, input logic dv,
                                input logic br, input logic exc,
                                input logic im, input logic dm);
      hz.i_load_use     = lu;
      hz.i_mul_start    = mul;
      hz.i_div_start    = dv;
      hz.i_branch_taken = br;
      hz.i_mem_exc      = exc;
      hz.i_imem_stall   = im;
      hz.i_dmem_stall   = dm;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [11:0] expected);
      logic [11:0] observed;
      observed = {hz.o_pc_we, hz.o_if_id_we, hz.o_id_ex_we, hz.o_ex_mem_we,
                  hz.o_mem_wb_we, hz.o_if_id_flush, hz.o_id_ex_flush,
                  hz.o_ex_mem_flush, hz.o_mem_wb_flush, hz.o_pc_sel_exc,
                  hz.o_ex_busy, hz.o_muldiv_done};
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

`ifdef PIPE_HAZARD_PERF_EN
   task automatic checkPerf(input string tag, input logic [31:0] exp_stall,
                            input logic [31:0] exp_flush);
      checks++;
      assert (stall_cycles === exp_stall) else begin
         errors++;
         $error("[TB] FAIL %s stall_cycles: observed=%0d expected=%0d", tag,
                stall_cycles, exp_stall);
      end
      checks++;
      assert (flush_events === exp_flush) else begin
         errors++;
         $error("[TB] FAIL %s flush_events: observed=%0d expected=%0d", tag,
                flush_events, exp_flush);
      end
   endtask
`endif

   // Advance one clock and settle away from the active edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      resetn = 1'b0;

      // Inputs active during reset must not leak to the outputs.
      applyStimulus(1, 1, 1, 1, 1, 1, 1);
      checkOutput("reset_outputs", P_IDLE);
`ifdef PIPE_HAZARD_PERF_EN
      checkPerf("reset_perf", 32'd0, 32'd0);
`endif
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      #1;

      // Idle pipeline after reset release.
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("idle_%0d", i), P_IDLE);
         tick();
      end
`ifdef PIPE_HAZARD_PERF_EN
      checkPerf("idle_perf", 32'd0, 32'd0);
`endif

      // Single-cycle load-use bubble.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("load_use", P_LDUSE);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("after_load_use", P_IDLE);
`ifdef PIPE_HAZARD_PERF_EN
      checkPerf("load_use_perf", 32'd1, 32'd1);
`endif

      // Multiply held for 4 cycles: 3 busy cycles, then DONE.
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("mul_c1", P_BUSY);
      tick();
      checkOutput("mul_c2", P_BUSY);
      tick();
      checkOutput("mul_c3", P_BUSY);
      tick();
      checkOutput("mul_c4_done", P_DONE);
      // A dmem stall in DONE freezes everything and holds DONE.
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      checkOutput("mul_done_dstall", P_DSTALL);
      tick();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("mul_done_held", P_DONE);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("mul_c5_run", P_IDLE);
      // A start here proves the FSM is back in RUN (no clock taken).
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("mul_c5_restart_seen", P_BUSY);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Divide with a 5-cycle dmem stall inside BUSY: 38 busy, DONE on 39.
      for (int c = 1; c <= 38; c++) begin
         applyStimulus(0, 0, 1, 0, 0, 0, (c >= 10 && c <= 14));
         checkOutput($sformatf("div_c%0d", c),
                     (c >= 10 && c <= 14) ? P_BSTALL : P_BUSY);
         tick();
      end
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("div_c39_done", P_DONE);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("div_after", P_IDLE);

      // Exception on cycle 10 of a divide aborts it.
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      for (int c = 1; c <= 9; c++) begin
         tick();
      end
      applyStimulus(0, 0, 1, 0, 1, 0, 0);
      checkOutput("div_exc_c10", P_EXCBUSY);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("div_exc_next_run", P_IDLE);

      // Exception overrides a simultaneous dmem stall.
      applyStimulus(0, 0, 0, 0, 1, 0, 1);
      checkOutput("exc_over_dstall", P_EXC);
      tick();

      // Branch beats load-use and imem stall.
      applyStimulus(1, 0, 0, 1, 0, 1, 0);
      checkOutput("branch_lu_imem", P_BRANCH);
      tick();

      // Imem stall alone, and load-use over imem stall.
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("imem_stall", P_IMEM);
      applyStimulus(1, 0, 0, 0, 0, 1, 0);
      checkOutput("lu_over_imem", P_LDUSE);
      tick();

      // Branch and load-use are ignored while EX is busy.
      applyStimulus(1, 1, 0, 1, 0, 0, 0);
      checkOutput("busy_ignores_branch", P_BUSY);
      tick();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("busy_branch_done", P_DONE);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("busy_branch_after", P_IDLE);

      // Start held through a dmem freeze in RUN loads the counter once.
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      checkOutput("frozen_start", P_BSTALL);
      tick();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("frozen_b1", P_BUSY);
      tick();
      checkOutput("frozen_b2", P_BUSY);
      tick();
      checkOutput("frozen_done", P_DONE);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("frozen_after", P_IDLE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
